// File: rtl/ghr_spec_ctrl.sv
// Global history register sequencer for a speculative front end.
// Keeps speculative and architectural histories plus an in-order FIFO of predictions.
module ghr_spec_ctrl #(
    parameter int HISTORY_SIZE = 64,
    parameter int DEPTH        = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pred_valid,
    input  logic                       pred_taken,
    output logic                       pred_ready,
    input  logic                       resolve_valid,
    input  logic                       resolve_taken,
    input  logic                       flush,
    output logic [HISTORY_SIZE-1:0]    spec_history,
    output logic [HISTORY_SIZE-1:0]    arch_history,
    output logic [$clog2(DEPTH):0]     inflight_count,
    output logic                       mispredict,
    output logic                       underflow_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {
        NORMAL,
        RECOVER
    } state_t;

    state_t                  state;
    logic [DEPTH-1:0]        fifo;
    logic [PW-1:0]           head;
    logic [PW-1:0]           tail;
    logic [CW-1:0]           count;

    logic                    push;
    logic                    res;
    logic                    mis;
    logic                    head_bit;
    logic [HISTORY_SIZE-1:0] arch_next;

    // Readiness depends only on registered state.
    assign pred_ready     = (state == NORMAL) && (count != FULL);
    assign inflight_count = count;

    // Decode this cycle's events and the post-resolve architectural history.
    always_comb begin
        head_bit  = fifo[head];
        push      = pred_valid && pred_ready;
        res       = resolve_valid && (count != '0);
        mis       = res && (head_bit != resolve_taken);
        arch_next = arch_history;
        if (res) begin
            arch_next = {arch_history[HISTORY_SIZE-2:0], resolve_taken};
        end
    end

    // Histories, FIFO pointers, recovery state and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= NORMAL;
            fifo          <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            spec_history  <= '0;
            arch_history  <= '0;
            mispredict    <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            mispredict    <= mis;
            underflow_err <= resolve_valid && (count == '0);
            arch_history  <= arch_next;
            if (flush || mis) begin
                // Squash everything in flight; a same-cycle push is dropped.
                spec_history <= arch_next;
                head         <= '0;
                tail         <= '0;
                count        <= '0;
                state        <= RECOVER;
            end else begin
                state <= NORMAL;
                if (push) begin
                    fifo[tail]   <= pred_taken;
                    tail         <= tail + PW'(1);
                    spec_history <= {spec_history[HISTORY_SIZE-2:0], pred_taken};
                end
                if (res) begin
                    head <= head + PW'(1);
                end
                if (push && !res) begin
                    count <= count + CW'(1);
                end else if (!push && res) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ghr_spec_ctrl.sv
// Self-checking bench for ghr_spec_ctrl (HISTORY_SIZE=8, DEPTH=4).
// A queue-based reference model tracks the expected histories and FIFO.
module tb_ghr_spec_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       pred_valid;
    logic       pred_taken;
    logic       pred_ready;
    logic       resolve_valid;
    logic       resolve_taken;
    logic       flush;
    logic [7:0] spec_history;
    logic [7:0] arch_history;
    logic [2:0] inflight_count;
    logic       mispredict;
    logic       underflow_err;

    int checks = 0;
    int errors = 0;

    bit         m_q[$];
    logic [7:0] m_spec;
    logic [7:0] m_arch;
    bit         m_rec;
    bit         m_mis;
    bit         m_unf;

    ghr_spec_ctrl #(.HISTORY_SIZE(8), .DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .pred_valid     (pred_valid),
        .pred_taken     (pred_taken),
        .pred_ready     (pred_ready),
        .resolve_valid  (resolve_valid),
        .resolve_taken  (resolve_taken),
        .flush          (flush),
        .spec_history   (spec_history),
        .arch_history   (arch_history),
        .inflight_count (inflight_count),
        .mispredict     (mispredict),
        .underflow_err  (underflow_err)
    );

    always #5 clk = ~clk;

    function automatic bit m_ready();
        return !m_rec && (m_q.size() != 4);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_spec = '0;
        m_arch = '0;
        m_rec  = 0;
        m_mis  = 0;
        m_unf  = 0;
    endtask

    task automatic model_step(input bit pv, pt, rv, rt, fl);
        bit acc;
        bit mis;
        bit p;
        acc   = pv && m_ready();
        m_unf = rv && (m_q.size() == 0);
        mis   = 0;
        if (rv && m_q.size() > 0) begin
            p      = m_q.pop_front();
            m_arch = {m_arch[6:0], rt};
            mis    = (p != rt);
        end
        if (fl || mis) begin
            m_spec = m_arch;
            m_q.delete();
            m_rec = 1;
        end else begin
            m_rec = 0;
            if (acc) begin
                m_q.push_back(pt);
                m_spec = {m_spec[6:0], pt};
            end
        end
        m_mis = mis;
    endtask

    task automatic cycle(input bit pv, pt, rv, rt, fl);
        pred_valid    = pv;
        pred_taken    = pt;
        resolve_valid = rv;
        resolve_taken = rt;
        flush         = fl;
        @(posedge clk);
        model_step(pv, pt, rv, rt, fl);
        #1;
        pred_valid    = 0;
        pred_taken    = 0;
        resolve_valid = 0;
        resolve_taken = 0;
        flush         = 0;
    endtask

    task automatic test_reset();
        pred_valid    = 0;
        pred_taken    = 0;
        resolve_valid = 0;
        resolve_taken = 0;
        flush         = 0;
        rst           = 1;
        model_reset();
        #13;
        checks++;
        if (spec_history !== 8'h00 || arch_history !== 8'h00) begin
            errors++;
            $display("FAIL reset_hist spec=%h arch=%h want 00/00",
                     spec_history, arch_history);
        end
        checks++;
        if (inflight_count !== 3'd0 || mispredict !== 1'b0 || underflow_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_status cnt=%0d mis=%b unf=%b want 0/0/0",
                     inflight_count, mispredict, underflow_err);
        end
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        checks++;
        if (pred_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got=%b want 1", pred_ready);
        end
    endtask

    task automatic test_fill();
        cycle(1, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        checks++;
        if (spec_history !== 8'b0000_1011) begin
            errors++;
            $display("FAIL fill_spec got=%b want 00001011", spec_history);
        end
        checks++;
        if (inflight_count !== 3'd4 || pred_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full cnt=%0d rdy=%b want 4/0",
                     inflight_count, pred_ready);
        end
        cycle(1, 1, 0, 0, 0);
        checks++;
        if (spec_history !== 8'b0000_1011 || inflight_count !== 3'd4) begin
            errors++;
            $display("FAIL fill_ignored spec=%b cnt=%0d want 00001011/4",
                     spec_history, inflight_count);
        end
    endtask

    task automatic test_correct_resolve();
        cycle(0, 0, 1, 1, 0);
        checks++;
        if (mispredict !== 1'b0) begin
            errors++;
            $display("FAIL correct_mis1 got=%b want 0", mispredict);
        end
        cycle(0, 0, 1, 0, 0);
        checks++;
        if (mispredict !== 1'b0) begin
            errors++;
            $display("FAIL correct_mis2 got=%b want 0", mispredict);
        end
        checks++;
        if (arch_history !== 8'b0000_0010 || inflight_count !== 3'd2) begin
            errors++;
            $display("FAIL correct_arch arch=%b cnt=%0d want 00000010/2",
                     arch_history, inflight_count);
        end
        checks++;
        if (spec_history !== 8'b0000_1011) begin
            errors++;
            $display("FAIL correct_spec got=%b want 00001011", spec_history);
        end
    endtask

    task automatic test_mispredict();
        cycle(1, 1, 1, 0, 0);
        checks++;
        if (spec_history !== 8'b0000_0100 || arch_history !== 8'b0000_0100) begin
            errors++;
            $display("FAIL mis_hist spec=%b arch=%b want 00000100",
                     spec_history, arch_history);
        end
        checks++;
        if (inflight_count !== 3'd0 || mispredict !== 1'b1 || pred_ready !== 1'b0) begin
            errors++;
            $display("FAIL mis_status cnt=%0d mis=%b rdy=%b want 0/1/0",
                     inflight_count, mispredict, pred_ready);
        end
        cycle(0, 0, 0, 0, 0);
        checks++;
        if (pred_ready !== 1'b1 || mispredict !== 1'b0) begin
            errors++;
            $display("FAIL mis_after rdy=%b mis=%b want 1/0",
                     pred_ready, mispredict);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1'($urandom), 0, 0, 0);
        end
        for (int i = 0; i < 20; i++) begin
            cycle(1, 1'($urandom), 1, m_q[0], 0);
            checks++;
            if (inflight_count !== 3'd3 || mispredict !== 1'b0) begin
                errors++;
                $display("FAIL b2b_cnt i=%0d cnt=%0d mis=%b want 3/0",
                         i, inflight_count, mispredict);
            end
            checks++;
            if (spec_history !== m_spec || arch_history !== m_arch) begin
                errors++;
                $display("FAIL b2b_hist i=%0d spec=%b arch=%b want %b/%b",
                         i, spec_history, arch_history, m_spec, m_arch);
            end
        end
    endtask

    task automatic test_flush();
        logic [7:0] exp_arch;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1, m_q[0], 0);
        end
        cycle(1, 1, 0, 0, 0);
        cycle(1, 1'($urandom), 0, 0, 0);
        cycle(1, 1'($urandom), 0, 0, 0);
        exp_arch = {arch_history[6:0], 1'b1};
        cycle(1, 1, 1, 1, 1);
        checks++;
        if (arch_history !== exp_arch || spec_history !== exp_arch) begin
            errors++;
            $display("FAIL flush_hist arch=%b spec=%b want %b",
                     arch_history, spec_history, exp_arch);
        end
        checks++;
        if (inflight_count !== 3'd0 || pred_ready !== 1'b0 || mispredict !== 1'b0) begin
            errors++;
            $display("FAIL flush_status cnt=%0d rdy=%b mis=%b want 0/0/0",
                     inflight_count, pred_ready, mispredict);
        end
        cycle(0, 0, 0, 0, 0);
        checks++;
        if (pred_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_recover rdy=%b want 1", pred_ready);
        end
    endtask

    task automatic test_underflow_reset();
        logic [7:0] s0;
        logic [7:0] a0;
        s0 = spec_history;
        a0 = arch_history;
        cycle(0, 0, 1, 1, 0);
        checks++;
        if (underflow_err !== 1'b1 || spec_history !== s0 || arch_history !== a0) begin
            errors++;
            $display("FAIL unf_pulse unf=%b spec=%b arch=%b want 1/%b/%b",
                     underflow_err, spec_history, arch_history, s0, a0);
        end
        cycle(0, 0, 0, 0, 0);
        checks++;
        if (underflow_err !== 1'b0) begin
            errors++;
            $display("FAIL unf_once got=%b want 0", underflow_err);
        end
        cycle(1, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        checks++;
        if (mispredict !== 1'b1 || pred_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_setup mis=%b rdy=%b want 1/0",
                     mispredict, pred_ready);
        end
        rst = 1;
        #2;
        model_reset();
        checks++;
        if (spec_history !== 8'h00 || arch_history !== 8'h00 ||
            inflight_count !== 3'd0 || mispredict !== 1'b0 ||
            underflow_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_async spec=%b arch=%b cnt=%0d mis=%b unf=%b want zeros",
                     spec_history, arch_history, inflight_count,
                     mispredict, underflow_err);
        end
        @(negedge clk);
        rst = 0;
        #1;
        checks++;
        if (pred_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_release rdy=%b want 1", pred_ready);
        end
    endtask

    task automatic test_random();
        bit pv;
        bit pt;
        bit rv;
        bit rt;
        bit fl;
        for (int i = 0; i < 400; i++) begin
            pv = ($urandom_range(0, 99) < 60);
            pt = 1'($urandom);
            rv = ($urandom_range(0, 99) < 45);
            fl = ($urandom_range(0, 99) < 4);
            if (m_q.size() > 0 && $urandom_range(0, 99) < 80) begin
                rt = m_q[0];
            end else begin
                rt = 1'($urandom);
            end
            cycle(pv, pt, rv, rt, fl);
            checks++;
            if (spec_history !== m_spec || arch_history !== m_arch ||
                inflight_count !== 3'(m_q.size()) || pred_ready !== m_ready() ||
                mispredict !== m_mis || underflow_err !== m_unf) begin
                errors++;
                $display("FAIL rand i=%0d spec=%b arch=%b cnt=%0d rdy=%b mis=%b unf=%b want %b/%b/%0d/%b/%b/%b",
                         i, spec_history, arch_history, inflight_count,
                         pred_ready, mispredict, underflow_err,
                         m_spec, m_arch, m_q.size(), m_ready(), m_mis, m_unf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_correct_resolve();
        test_mispredict();
        test_back_to_back();
        test_flush();
        test_underflow_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
